// File: rtl/rr_arb_mux.sv
// Parametrised round-robin arbitrating N:1 mux with a one-entry registered output.
// Define RR_ARB_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for whole packets.
module rr_arb_mux #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    input  logic [N_IN-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] ptr_next;
    logic [WIDTH-1:0] sel_data;
    logic             any_valid;
    logic             load;
    logic             xfer;
    logic             last_beat;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic             locked;
`endif

    // First valid channel at or after ptr, wrapping modulo N_IN.
    always_comb begin : arbitrate
        any_valid = 1'b0;
        grant     = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            int unsigned idx;
            idx = 32'(ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!any_valid && in_valid[SEL_W'(idx)]) begin
                any_valid = 1'b1;
                grant     = SEL_W'(idx);
            end
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // out_src always names the channel of the last transfer, i.e. the locked owner.
        if (locked) begin
            any_valid = in_valid[out_src];
            grant     = out_src;
        end
`endif
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = !rst && load && any_valid;
    assign sel_data = in_data[32'(grant)*WIDTH +: WIDTH];
    assign ptr_next = (32'(grant) == N_IN - 1) ? '0 : grant + SEL_W'(1);

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    assign last_beat = in_last[grant];
`else
    assign last_beat = 1'b1;
`endif

    always_comb begin : ready_gen
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant;
            if (last_beat) begin
                ptr <= ptr_next;
            end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            out_last  <= in_last[grant];
            locked    <= !in_last[grant];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomised and directed bench for rr_arb_mux against a queue-free behavioural model.
// Follows RR_ARB_MUX_PKT_LOCK_EN when defined.
`timescale 1ns/1ps
module tb_rr_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   din [N];
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     out_src;

    logic [23:0]    in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [7:0]     out_data3;
    logic           out_valid3;
    logic [1:0]     out_src3;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
    logic           out_last3;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    bit         m_last;
    bit         m_locked;
    int         m_lock_ch;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = din[i];
    end

    rr_arb_mux #(.WIDTH(W), .N_IN(N)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src)
    );

    rr_arb_mux #(.WIDTH(8), .N_IN(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .in_last(3'b111), .out_last(out_last3),
`endif
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(1'b1), .out_src(out_src3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Grant this cycle per the arbitration rules, -1 when nobody is accepted.
    function automatic int m_grant();
        if (rst || (m_valid && !out_ready)) return -1;
        if (m_locked) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One clock: check in_ready, advance model at the edge, check outputs at negedge.
    task automatic tick();
        int           g;
        logic [N-1:0] er;
        #1;
        g  = m_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(er));
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_last = 0; m_locked = 0; m_lock_ch = 0;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = din[g];
            m_src   = g;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            m_last = in_last[g];
            if (in_last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked  = 1;
                m_lock_ch = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_src", 64'(out_src), 64'(m_src));
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        check("out_last", 64'(out_last), 64'(m_last));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pkt_src [4];
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b0;
        in_valid3 = '0;
        in_data3  = {8'h32, 8'h31, 8'h30};
        for (int i = 0; i < N; i++) din[i] = 32'h0000_00A0 + 32'(i);
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        in_last = '1;
`endif
        m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0; m_last = 0; m_locked = 0; m_lock_ch = 0;
        @(negedge clk);

        // Reset held for two cycles with every channel requesting
        tick();
        tick();
        check("rst_out_data", 64'(out_data), 64'h0);

        // Full-throughput rotation starting from channel 0
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rot_src", 64'(out_src), 64'(i % 4));
            check("rot_data", 64'(out_data), 64'(32'hA0 + 32'(i % 4)));
        end

        // Sparse request with ptr=2: channel 3, wrap, channel 1
        in_valid = 4'b1010;
        tick();
        check("wrap_src3", 64'(out_src), 64'd3);
        tick();
        check("wrap_src1", 64'(out_src), 64'd1);

        // Stall with a held word from channel 2
        in_valid = 4'b0100;
        din[2]   = 32'hDEAD_BEEF;
        tick();
        out_ready = 1'b0;
        in_valid  = '1;
        for (int i = 0; i < 5; i++) begin
            din[i % N] = $urandom;
            tick();
            check("stall_data", 64'(out_data), 64'hDEAD_BEEF);
            check("stall_src", 64'(out_src), 64'd2);
            check("stall_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        din[0]    = 32'h1234_5678;
        tick();
        check("refill_valid", 64'(out_valid), 64'd1);
        check("refill_data", 64'(out_data), 64'h1234_5678);

        // Drain with nothing to refill
        in_valid = '0;
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Channel 1 three-beat packet while channel 0 also requests (ptr=1)
        in_valid = 4'b0011;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        pkt_src = '{1, 1, 1, 0};
`else
        pkt_src = '{1, 0, 1, 0};
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            in_last = (i == 2) ? 4'b1111 : 4'b1101;
`endif
            tick();
            check("pkt_src", 64'(out_src), 64'(pkt_src[i]));
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        in_last = '1;
`endif

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) din[c] = $urandom;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            for (int c = 0; c < N; c++) in_last[c] = ($urandom_range(0, 2) != 0);
`endif
            tick();
        end

        // Three-channel instance: non-power-of-two wrap
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid3 = 3'b111;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("n3_src", 64'(out_src3), 64'(i % 3));
            check("n3_data", 64'(out_data3), 64'(8'h30 + 8'(i % 3)));
            check("n3_valid", 64'(out_valid3), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
